// File: rtl/model_buffer.sv
// model_buffer: per-model triangle RAM with count-bounded read responder.
// Define MODELBUF_READ_ERROR_EN to get a sticky out-of-range read_error flag.
module model_buffer #(
   parameter int MAX_MODEL_COUNT    = 10,
   parameter int MAX_TRIANGLE_COUNT = 100,
   parameter int SHORT_W            = 16,
   parameter int TRI_W              = 144
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 write_in_valid,
   output logic                 write_in_ready,
   input  logic [TRI_W-1:0]     write_in_data,
   input  logic [SHORT_W-1:0]   write_in_model_index,
   input  logic [SHORT_W-1:0]   write_in_triangle_index,
   input  logic                 write_in_last,
   input  logic                 read_in_valid,
   output logic                 read_in_ready,
   input  logic [2*SHORT_W-1:0] read_in_data,
   output logic                 read_out_valid,
   input  logic                 read_out_ready,
   output logic [TRI_W-1:0]     read_out_data,
   output logic                 read_out_metadata,
   output logic                 read_error
);
   localparam int DEPTH = MAX_MODEL_COUNT * MAX_TRIANGLE_COUNT;
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = $clog2(MAX_TRIANGLE_COUNT + 1);
   localparam int MW    = MAX_MODEL_COUNT > 1 ? $clog2(MAX_MODEL_COUNT) : 1;
   localparam logic [SHORT_W-1:0] NM  = SHORT_W'(MAX_MODEL_COUNT);
   localparam logic [SHORT_W-1:0] NT  = SHORT_W'(MAX_TRIANGLE_COUNT);
   localparam logic [SHORT_W-1:0] ONE = SHORT_W'(1);

   logic [TRI_W-1:0]   mem [DEPTH];
   logic [CW-1:0]      cnt_q [MAX_MODEL_COUNT];
   logic [TRI_W-1:0]   rdata_q;
   logic               vld_q, hit_q, last_q;
   logic               vld_d, hit_d, last_d;
   logic [SHORT_W-1:0] rm, rt;
   logic [CW-1:0]      c;
   logic               w_ok, r_ok, acc;
   logic [AW-1:0]      waddr, raddr;

   assign {rm, rt} = read_in_data;

   always_comb begin
      w_ok   = write_in_valid && write_in_model_index < NM && write_in_triangle_index < NT;
      r_ok   = rm < NM && rt < NT;
      acc    = read_in_valid && read_in_ready;
      c      = r_ok ? cnt_q[MW'(rm)] : '0;
      hit_d  = r_ok && rt < SHORT_W'(c);
      // Misses still report last so the requester always terminates.
      last_d = !hit_d || rt + ONE == SHORT_W'(c);
      vld_d  = acc || (vld_q && !read_out_ready);
      waddr  = AW'(write_in_model_index * MAX_TRIANGLE_COUNT + write_in_triangle_index);
      raddr  = AW'(rm * MAX_TRIANGLE_COUNT + rt);
   end

   // No reset on the array or its output register so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (w_ok) mem[waddr] <= write_in_data;
      if (acc) rdata_q <= mem[raddr];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_q  <= 1'b0;
         hit_q  <= 1'b0;
         last_q <= 1'b0;
         for (int i = 0; i < MAX_MODEL_COUNT; i++) cnt_q[i] <= '0;
      end else begin
         vld_q <= vld_d;
         if (acc) begin
            hit_q  <= hit_d;
            last_q <= last_d;
         end
         if (w_ok && write_in_last) cnt_q[MW'(write_in_model_index)] <= CW'(write_in_triangle_index + ONE);
      end
   end

   assign write_in_ready    = 1'b1;
   assign read_in_ready     = !vld_q || read_out_ready;
   assign read_out_valid    = vld_q;
   assign read_out_data     = hit_q ? rdata_q : '0;
   assign read_out_metadata = last_q;

`ifdef MODELBUF_READ_ERROR_EN
   logic err_q;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) err_q <= 1'b0;
      else err_q <= err_q || (acc && !r_ok);
   end
   assign read_error = err_q;
`else
   assign read_error = 1'b0;
`endif
endmodule

// File: tb/tb_model_buffer.sv
// tb_model_buffer: directed plan plus random traffic against a queue/array reference model.
module tb_model_buffer;
   localparam int NM = 10;
   localparam int NT = 100;
   localparam int TW = 144;
`ifdef MODELBUF_READ_ERROR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rstn = 1'b1;
   logic          write_in_valid = 1'b0;
   logic          write_in_ready;
   logic [TW-1:0] write_in_data = '0;
   logic [15:0]   write_in_model_index = '0;
   logic [15:0]   write_in_triangle_index = '0;
   logic          write_in_last = 1'b0;
   logic          read_in_valid = 1'b0;
   logic          read_in_ready;
   logic [31:0]   read_in_data = '0;
   logic          read_out_valid;
   logic          read_out_ready = 1'b1;
   logic [TW-1:0] read_out_data;
   logic          read_out_metadata;
   logic          read_error;

   always #5 clk = ~clk;

   model_buffer dut (
      .clk(clk), .rstn(rstn),
      .write_in_valid(write_in_valid), .write_in_ready(write_in_ready),
      .write_in_data(write_in_data), .write_in_model_index(write_in_model_index),
      .write_in_triangle_index(write_in_triangle_index), .write_in_last(write_in_last),
      .read_in_valid(read_in_valid), .read_in_ready(read_in_ready), .read_in_data(read_in_data),
      .read_out_valid(read_out_valid), .read_out_ready(read_out_ready),
      .read_out_data(read_out_data), .read_out_metadata(read_out_metadata),
      .read_error(read_error)
   );

   typedef struct {
      logic [TW-1:0] d;
      logic          l;
   } rsp_t;

   rsp_t          q[$];
   logic [TW-1:0] mem_m [NM*NT];
   int            cnt_m [NM];
   logic          err_m = 1'b0;
   int            n_chk = 0;
   int            n_err = 0;
   logic [TW-1:0] ta, tb_, tc, td, te;

   task automatic check(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic [TW-1:0] rnd();
      logic [159:0] v;
      v = {$urandom, $urandom, $urandom, $urandom, $urandom};
      return v[TW-1:0];
   endfunction

   function automatic rsp_t expect_rsp(input int m, input int t);
      rsp_t r;
      r.d = '0;
      r.l = 1'b1;
      if (m < NM && t < NT && t < cnt_m[m]) begin
         r.d = mem_m[m*NT+t];
         r.l = (t == cnt_m[m] - 1);
      end
      return r;
   endfunction

   // Reference: reads see pre-edge memory and counts, then writes apply.
   always @(posedge clk) begin : model
      bit rdy;
      int m, t, wm, wt;
      if (rstn) begin
         rdy = q.size() == 0 || read_out_ready;
         m   = int'(read_in_data[31:16]);
         t   = int'(read_in_data[15:0]);
         wm  = int'(write_in_model_index);
         wt  = int'(write_in_triangle_index);
         if (q.size() != 0 && read_out_ready) void'(q.pop_front());
         if (read_in_valid && rdy) begin
            q.push_back(expect_rsp(m, t));
            if (ERR_EN && !(m < NM && t < NT)) err_m = 1'b1;
         end
         if (write_in_valid && wm < NM && wt < NT) begin
            mem_m[wm*NT+wt] = write_in_data;
            if (write_in_last) cnt_m[wm] = wt + 1;
         end
      end
   end

   always @(negedge clk) begin
      check("out_valid", read_out_valid, q.size() != 0);
      check("in_ready", read_in_ready, q.size() == 0 || read_out_ready);
      check("wr_ready", write_in_ready, 1'b1);
      check("error", read_error, err_m);
      if (q.size() != 0) begin
         check("data", read_out_data, q[0].d);
         check("last", read_out_metadata, q[0].l);
      end
   end

   task automatic cyc(input bit wv, input int wm, input int wt, input logic [TW-1:0] wd, input bit wl,
                      input bit rv, input int rm, input int rt, input bit ordy);
      write_in_valid          = wv;
      write_in_model_index    = 16'(wm);
      write_in_triangle_index = 16'(wt);
      write_in_data           = wd;
      write_in_last           = wl;
      read_in_valid           = rv;
      read_in_data            = {16'(rm), 16'(rt)};
      read_out_ready          = ordy;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int m, input int t, input logic [TW-1:0] d, input bit l);
      cyc(1'b1, m, t, d, l, 1'b0, 0, 0, 1'b1);
   endtask

   task automatic rd(input int m, input int t, input bit ordy);
      cyc(1'b0, 0, 0, '0, 1'b0, 1'b1, m, t, ordy);
   endtask

   task automatic do_reset();
      write_in_valid = 1'b0;
      read_in_valid  = 1'b0;
      #2;
      rstn = 1'b0;
      q.delete();
      foreach (cnt_m[i]) cnt_m[i] = 0;
      err_m = 1'b0;
      #1;
      check("rst_valid", read_out_valid, 1'b0);
      repeat (2) @(posedge clk);
      #2;
      rstn = 1'b1;
   endtask

   initial begin
      foreach (cnt_m[i]) cnt_m[i] = 0;
      #1;
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rstn = 1'b1;
      check("rst_in_ready", read_in_ready, 1'b1);
      check("rst_error", read_error, 1'b0);
      for (int a = 0; a < NM*NT; a++) wr(a / NT, a % NT, rnd(), 1'b0);
      ta = rnd(); tb_ = rnd(); tc = rnd(); td = rnd(); te = rnd();
      wr(2, 0, ta, 1'b0);
      wr(2, 1, tb_, 1'b0);
      wr(2, 2, tc, 1'b1);
      rd(2, 0, 1'b1); check("p_a", read_out_data, ta); check("p_a_last", read_out_metadata, 1'b0);
      rd(2, 1, 1'b1); check("p_b", read_out_data, tb_); check("p_b_last", read_out_metadata, 1'b0);
      rd(2, 2, 1'b1); check("p_c", read_out_data, tc); check("p_c_last", read_out_metadata, 1'b1);
      rd(2, 3, 1'b1); check("p_over", read_out_data, '0); check("p_over_last", read_out_metadata, 1'b1);
      cyc(1'b0, 0, 0, '0, 1'b0, 1'b0, 0, 0, 1'b1);
      rd(2, 0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         rd(2, 1, 1'b0);
         check("bp_ready", read_in_ready, 1'b0);
         check("bp_data", read_out_data, ta);
         check("bp_valid", read_out_valid, 1'b1);
      end
      rd(2, 1, 1'b1); check("bp_next", read_out_data, tb_); check("bp_next_last", read_out_metadata, 1'b0);
      rd(5, 0, 1'b1); check("unl_data", read_out_data, '0); check("unl_last", read_out_metadata, 1'b1);
      rd(12, 0, 1'b1); check("oor_data", read_out_data, '0); check("oor_last", read_out_metadata, 1'b1);
      cyc(1'b0, 0, 0, '0, 1'b0, 1'b0, 0, 0, 1'b1);
      check("oor_error", read_error, ERR_EN);
      wr(2, 0, ta, 1'b0);
      wr(2, 1, te, 1'b1);
      rd(2, 1, 1'b1); check("shr_e", read_out_data, te); check("shr_e_last", read_out_metadata, 1'b1);
      rd(2, 2, 1'b1); check("shr_gone", read_out_data, '0); check("shr_gone_last", read_out_metadata, 1'b1);
      cyc(1'b1, 2, 0, td, 1'b0, 1'b1, 2, 0, 1'b1);
      check("col_old", read_out_data, ta);
      rd(2, 0, 1'b1); check("col_new", read_out_data, td);
      rd(2, 0, 1'b0);
      do_reset();
      rd(2, 0, 1'b1); check("post_rst_data", read_out_data, '0); check("post_rst_last", read_out_metadata, 1'b1);
      rd(2, 1, 1'b1);
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 1) == 1, $urandom_range(0, 11),
             ($urandom_range(0, 7) == 0) ? $urandom_range(0, 110) : $urandom_range(0, 9),
             rnd(), $urandom_range(0, 5) == 0,
             $urandom_range(0, 2) != 0, $urandom_range(0, 11),
             ($urandom_range(0, 7) == 0) ? $urandom_range(0, 110) : $urandom_range(0, 11),
             $urandom_range(0, 3) != 0);
         if ($urandom_range(0, 999) == 0) do_reset();
      end
      repeat (3) cyc(1'b0, 0, 0, '0, 1'b0, 1'b0, 0, 0, 1'b1);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
